// File: rtl/demux4_tdm_e_high.sv
// Receive-side TDM demultiplexer: splits one lane of four rotating slots into a 4-lane frame.
// Optional misaligned-SYNC detection/realignment is enabled with `define DEMUX4_TDM_SYNC_CHECK_EN.
module demux4_tdm_e_high #(
  parameter int WIDTH       = 1,
  parameter int SLOT_CYCLES = 1
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               E,
  input  logic               SYNC,
  input  logic [WIDTH-1:0]   D,
  output logic [4*WIDTH-1:0] Y,
  output logic               Y_VALID,
  output logic [1:0]         S_OUT,
  output logic               LOCKED,
  output logic               ERR
);

  localparam int PW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam logic [PW-1:0] PH_LAST = PW'(SLOT_CYCLES - 1);
  // With one cycle per slot, the frame-start cycle already completes slot 0.
  localparam logic [1:0] START_SLOT = (SLOT_CYCLES == 1) ? 2'd1 : 2'd0;

  typedef enum logic {HUNT = 1'b0, RUN = 1'b1} state_t;

  state_t             state_q;
  logic [PW-1:0]      phase_q;
  logic [1:0]         slot_q;
  logic [WIDTH-1:0]   sh0_q, sh1_q, sh2_q;
  logic [4*WIDTH-1:0] y_q;
  logic               yv_q;
  logic               err_q;
  logic               misalign;

  function automatic logic [PW-1:0] phase_next(input logic [PW-1:0] p);
    return (p == PH_LAST) ? '0 : p + 1'b1;
  endfunction

`ifdef DEMUX4_TDM_SYNC_CHECK_EN
  assign misalign = SYNC && ((slot_q != 2'd0) || (phase_q != '0));
`else
  assign misalign = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= HUNT;
      phase_q <= '0;
      slot_q  <= 2'd0;
      sh0_q   <= '0;
      sh1_q   <= '0;
      sh2_q   <= '0;
      y_q     <= '0;
      yv_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      yv_q  <= 1'b0;
      err_q <= 1'b0;
      if (!E) begin
        // Disabled: drop any partial frame but keep the last delivered Y.
        state_q <= HUNT;
        phase_q <= '0;
        slot_q  <= 2'd0;
        sh0_q   <= '0;
        sh1_q   <= '0;
        sh2_q   <= '0;
      end else begin
        case (state_q)
          HUNT: begin
            if (SYNC) begin
              state_q <= RUN;
              sh0_q   <= D;
              phase_q <= phase_next('0);
              slot_q  <= START_SLOT;
            end
          end
          RUN: begin
            if (misalign) begin
              sh0_q   <= D;
              phase_q <= phase_next('0);
              slot_q  <= START_SLOT;
              err_q   <= 1'b1;
            end else begin
              if (phase_q == '0) begin
                case (slot_q)
                  2'd0:    sh0_q <= D;
                  2'd1:    sh1_q <= D;
                  2'd2:    sh2_q <= D;
                  default: begin
                    y_q  <= {D, sh2_q, sh1_q, sh0_q};
                    yv_q <= 1'b1;
                  end
                endcase
              end
              phase_q <= phase_next(phase_q);
              if (phase_q == PH_LAST) slot_q <= slot_q + 2'd1;
            end
          end
          default: state_q <= HUNT;
        endcase
      end
    end
  end

  assign Y       = y_q;
  assign Y_VALID = yv_q;
  assign S_OUT   = slot_q;
  assign LOCKED  = (state_q == RUN);
  assign ERR     = err_q;

endmodule

// File: tb/tb_demux4_tdm_e_high.sv
// Directed bench for demux4_tdm_e_high: a 1-bit/1-cycle instance and a 4-bit/3-cycle instance.
module tb_demux4_tdm_e_high;

`ifdef DEMUX4_TDM_SYNC_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic CLK = 1'b0;
  logic rst_n;
  always #5 CLK = ~CLK;

  logic       e0, s0, d0;
  logic [3:0] y0;
  logic       yv0, lk0, er0;
  logic [1:0] so0;

  logic        e1, s1;
  logic [3:0]  d1;
  logic [15:0] y1;
  logic        yv1, lk1, er1;
  logic [1:0]  so1;

  demux4_tdm_e_high #(.WIDTH(1), .SLOT_CYCLES(1)) u0 (
    .CLK(CLK), .RST_N(rst_n), .E(e0), .SYNC(s0), .D(d0),
    .Y(y0), .Y_VALID(yv0), .S_OUT(so0), .LOCKED(lk0), .ERR(er0)
  );

  demux4_tdm_e_high #(.WIDTH(4), .SLOT_CYCLES(3)) u1 (
    .CLK(CLK), .RST_N(rst_n), .E(e1), .SYNC(s1), .D(d1),
    .Y(y1), .Y_VALID(yv1), .S_OUT(so1), .LOCKED(lk1), .ERR(er1)
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  logic [3:0] vals [4];

  initial begin
    vals = '{4'hA, 4'hB, 4'hC, 4'hD};
    rst_n = 1'b0;
    e0 = 0; s0 = 0; d0 = 0;
    e1 = 0; s1 = 0; d1 = 0;
    step(); step();
    chk("rst_y0", y0, 0);
    chk("rst_yv0", yv0, 0);
    chk("rst_lk0", lk0, 0);
    chk("rst_so0", so0, 0);
    chk("rst_er0", er0, 0);
    chk("rst_y1", y1, 0);
    chk("rst_lk1", lk1, 0);
    rst_n = 1'b1;

    // Idle with E low while SYNC toggles
    for (int i = 0; i < 4; i++) begin
      s0 = i[0];
      step();
      chk("idle_lk0", lk0, 0);
      chk("idle_yv0", yv0, 0);
      chk("idle_y0", y0, 0);
      chk("idle_so0", so0, 0);
    end

    // Basic frame D=1,0,1,1 then back-to-back 0,1,1,0
    e0 = 1; s0 = 1; d0 = 1;
    chk("bf_so_c0", so0, 0);
    step();
    chk("bf_so_c1", so0, 1);
    chk("bf_lk_c1", lk0, 1);
    chk("bf_yv_c1", yv0, 0);
    s0 = 0; d0 = 0;
    step();
    chk("bf_so_c2", so0, 2);
    d0 = 1;
    step();
    chk("bf_so_c3", so0, 3);
    chk("bf_yv_c3", yv0, 0);
    d0 = 1;
    step();
    chk("bf_yv_c4", yv0, 1);
    chk("bf_y_c4", y0, 4'b1101);
    chk("bf_so_c4", so0, 0);
    d0 = 0;
    step();
    chk("b2b_yv_c5", yv0, 0);
    chk("b2b_y_hold", y0, 4'b1101);
    d0 = 1;
    step();
    chk("b2b_yv_c6", yv0, 0);
    d0 = 1;
    step();
    chk("b2b_yv_c7", yv0, 0);
    d0 = 0;
    step();
    chk("b2b_yv_c8", yv0, 1);
    chk("b2b_y_c8", y0, 4'b0110);

    // Enable drop at slot 2
    d0 = 1;
    step();
    d0 = 1;
    step();
    chk("ed_so_slot2", so0, 2);
    e0 = 0;
    step();
    chk("ed_lk", lk0, 0);
    chk("ed_yv", yv0, 0);
    chk("ed_y_hold", y0, 4'b0110);
    chk("ed_so", so0, 0);
    step();
    chk("ed_yv2", yv0, 0);
    chk("ed_y_hold2", y0, 4'b0110);
    e0 = 1; s0 = 1; d0 = 0;
    step();
    s0 = 0; d0 = 1;
    step();
    d0 = 0;
    step();
    chk("rs_yv_pre", yv0, 0);
    d0 = 0;
    step();
    chk("rs_yv", yv0, 1);
    chk("rs_y", y0, 4'b0010);

    // SYNC arriving at slot 2
    s0 = 1; d0 = 1;
    step();
    s0 = 0; d0 = 1;
    step();
    chk("ma_so_slot2", so0, 2);
    s0 = 1; d0 = 0;
    step();
    chk("ma_err", er0, CHK_EN ? 1 : 0);
    chk("ma_so", so0, CHK_EN ? 1 : 3);
    chk("ma_lk", lk0, 1);
    s0 = 0; d0 = 1;
    step();
    chk("ma_yv_c4", yv0, CHK_EN ? 0 : 1);
    chk("ma_y_c4", y0, CHK_EN ? 4'b0010 : 4'b1011);
    chk("ma_err_once", er0, 0);
    d0 = 1;
    step();
    d0 = 1;
    step();
    chk("ma_yv_c6", yv0, CHK_EN ? 1 : 0);
    chk("ma_y_c6", y0, CHK_EN ? 4'b1110 : 4'b1011);

    // Slot stretching on the 4-bit, 3-cycle instance; mid-slot D is garbage
    e1 = 1;
    for (int k = 0; k < 12; k++) begin
      chk("st_so", so1, k / 3);
      chk("st_yv", yv1, (k == 10) ? 1 : 0);
      if (k == 10) chk("st_y", y1, 16'hDCBA);
      s1 = (k == 0);
      d1 = (k % 3 == 0) ? vals[k / 3] : 4'hF;
      step();
    end
    chk("st_y_hold", y1, 16'hDCBA);
    chk("st_yv_end", yv1, 0);
    chk("st_lk", lk1, 1);
    chk("st_so_wrap", so1, 0);
    chk("st_err", er1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/demux4_tdm_e_high.md
Name: demux4_tdm_e_high

Overview:
- Receive-side counterpart of the 4:1 enable-high selector.
- Takes one time-division-multiplexed lane carrying four channels in rotating slots 0..3, with a frame-sync marker on slot 0.
- Splits the lane back into four parallel channel registers.
- Presents a complete frame on all four outputs at once, with a one-cycle valid strobe.

Parameters:
- WIDTH, 1: bits per channel slot (width of D and of each Y lane).
- SLOT_CYCLES, 1: clock cycles each slot occupies on D (>=1). D is sampled on the first cycle of each slot.

Ports:
- CLK  input  1  rising-edge clock
- RST_N  input  1  asynchronous active-low reset
- E  input  1  active-high enable; low forces the block back to HUNT
- SYNC  input  1  frame marker; high on the first cycle of slot 0
- D  input  WIDTH  multiplexed data lane
- Y  output  4*WIDTH  demultiplexed frame; lane k = Y[k*WIDTH +: WIDTH] = slot k
- Y_VALID  output  1  one-cycle pulse when Y updates
- S_OUT  output  2  slot index sampled this cycle (0 when not locked)
- LOCKED  output  1  high while in RUN
- ERR  output  1  one-cycle pulse on a misplaced SYNC (optional feature only)

Behaviour:
- Reset (RST_N low, async): Y=0, Y_VALID=0, ERR=0, S_OUT=0, LOCKED=0, state=HUNT, slot=0, phase=0, shadow=0.
- Internal state:
  - phase counter 0..SLOT_CYCLES-1, width max(1, clog2(SLOT_CYCLES)).
  - slot counter 2 bits; wraps 3->0.
  - shadow registers for slots 0..2.
- HUNT:
  - Waits for E=1 and SYNC=1 in the same cycle.
  - On that cycle: shadow0<=D, phase advances, next state RUN.
  - If SLOT_CYCLES=1, slot advances to 1.
- RUN, every cycle with E=1:
  - phase increments; on wrap from SLOT_CYCLES-1 to 0, slot increments.
  - When phase==0: D is captured into shadow[slot] for slots 0..2.
  - At slot 3, phase 0: next edge sets Y <= {D, shadow2, shadow1, shadow0} and pulses Y_VALID high for exactly one cycle.
  - Latency: Y_VALID rises 1 cycle after the slot-3 sample.
  - Y holds between frames.
- SYNC at the expected point (slot 0, phase 0 in RUN) is accepted silently.
- Missing SYNC at a frame boundary: keep running free (flywheel); no error.
- E falls (any state): next edge goes to HUNT.
  - slot, phase and shadow are cleared.
  - Any partial frame is discarded with no Y_VALID.
  - Y keeps its last value; LOCKED=0.
- E=1 and SYNC=1 in the same cycle that E returns: handled as in HUNT.
- Reset mid-frame: immediate return to the reset values; partial frame lost.
- S_OUT is the registered slot counter; it reads 0 in HUNT.

Optional Feature:
- Macro: DEMUX4_TDM_SYNC_CHECK_EN.
- Defined:
  - SYNC in RUN at any point other than slot 0 / phase 0 is a misalignment.
  - That cycle is treated as slot 0 / phase 0 of a new frame (shadow0<=D, counters restarted).
  - The partial frame is dropped with no Y_VALID.
  - ERR pulses high for one cycle on the next edge.
  - LOCKED stays 1.
- Not defined:
  - SYNC is ignored while in RUN; alignment is set only from HUNT.
  - ERR is tied to 0.

Test Plan:
- Reset/idle: RST_N low, then high with E=0 and SYNC pulsing -> Y=0, Y_VALID=0, LOCKED=0, S_OUT=0 throughout.
- Basic frame (WIDTH=1, SLOT_CYCLES=1): E=1; SYNC on cycle 0; D=1,0,1,1 over cycles 0..3 -> Y=4'b1101 after the cycle-3 edge; Y_VALID high only for cycle 4; S_OUT reads 0,1,2,3.
- Back-to-back frames with SYNC only on the first: D=1,0,1,1 then 0,1,1,0 -> Y=4'b1101, then 4'b0110; Y_VALID pulses exactly 4 cycles apart.
- Slot stretching (WIDTH=4, SLOT_CYCLES=3): values A,B,C,D each held 3 cycles -> Y=16'hDCBA; Y_VALID one cycle after the first cycle of slot 3; D changes mid-slot are ignored.
- Enable drop: E=0 at slot 2 -> LOCKED=0 next cycle, no Y_VALID, Y unchanged; after re-sync, the next full frame updates Y.
- Misaligned SYNC (macro defined): SYNC at slot 2 -> ERR pulses once, slot restarts at 0, the old frame produces no Y_VALID, and the new frame completes 4 slots later. Without the macro: the frame completes normally and ERR stays 0.
